// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_pkg : shared types and helpers for the data memory responder           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} mem_size_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} resp_state_t;

  localparam int c_LANES = 4;

  // Size/alignment part of the error check; range is checked by the top.
  function automatic logic f_bad_access(mem_size_t sz, logic [1:0] lo);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return |lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// +----------------------------------------------------------------------------+
// | mem_lane_align : byte-enable/write-lane steering and load extraction       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_lane_align
  import mem_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [1:0]         i_size,
  input  logic [1:0]         i_addr_lo,
  input  logic               i_unsigned,
  input  logic [D_WIDTH-1:0] i_wdata,
  input  logic [D_WIDTH-1:0] i_rword,
  output logic [c_LANES-1:0] o_be,
  output logic [D_WIDTH-1:0] o_wdata,
  output logic [D_WIDTH-1:0] o_rdata
);

  mem_size_t          w_size;
  logic [D_WIDTH-1:0] w_shifted;

  assign w_size    = mem_size_t'(i_size);
  assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

  // Replicating the narrow value puts it on every lane; byte enables pick the live one.
  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_rdata = '0;
    case (w_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_H: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      end
      SZ_W: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +----------------------------------------------------------------------------+
// | data_mem_responder : load/store responder with fixed wait-state latency    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem_responder
  import mem_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 17,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_unsigned_i,
  input  logic [D_WIDTH-1:0] req_addr_i,
  input  logic [D_WIDTH-1:0] req_wdata_i,
  output logic               resp_valid_o,
  output logic [D_WIDTH-1:0] resp_rdata_o,
  output logic               resp_err_o
);

  localparam int         c_DEPTH  = 2 ** (A_WIDTH - 2);
  localparam logic [3:0] c_LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  resp_state_t        r_state;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_uns;
  logic [D_WIDTH-1:0] r_addr;
  logic [D_WIDTH-1:0] r_wdata;
  logic               r_resp_valid;
  logic [D_WIDTH-1:0] r_resp_rdata;
  logic               r_resp_err;

  logic               w_accept;
  logic               w_in_idle;
  logic               w_we;
  logic [1:0]         w_size;
  logic               w_uns;
  logic [D_WIDTH-1:0] w_addr;
  logic [D_WIDTH-1:0] w_wdata;
  logic               w_err;
  logic               w_enter_resp;
  logic               w_commit;
  logic [A_WIDTH-3:0] w_idx;
  logic [c_LANES-1:0] w_be;
  logic [D_WIDTH-1:0] w_wdata_sh;
  logic [D_WIDTH-1:0] w_rword;
  logic [D_WIDTH-1:0] w_rdata_ext;

  assign req_ready_o = (r_state == S_IDLE) & ~rst;
  assign w_accept    = req_valid_i & req_ready_o;
  assign w_in_idle   = (r_state == S_IDLE);

  // With zero latency RESP is entered on the accept edge itself, so the live
  // request is used there; otherwise the captured copy is.
  assign w_we    = w_in_idle ? req_we_i       : r_we;
  assign w_size  = w_in_idle ? req_size_i     : r_size;
  assign w_uns   = w_in_idle ? req_unsigned_i : r_uns;
  assign w_addr  = w_in_idle ? req_addr_i     : r_addr;
  assign w_wdata = w_in_idle ? req_wdata_i    : r_wdata;

  assign w_err = f_bad_access(mem_size_t'(w_size), w_addr[1:0])
               | (|w_addr[D_WIDTH-1:A_WIDTH]);
  assign w_enter_resp = (w_accept && (LATENCY == 0))
                      || ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_commit = w_enter_resp & w_we & ~w_err & ~rst;
  assign w_idx    = w_addr[A_WIDTH-1:2];

  mem_lane_align #(
    .D_WIDTH (D_WIDTH)
  ) u_lane (
    .i_size     (w_size),
    .i_addr_lo  (w_addr[1:0]),
    .i_unsigned (w_uns),
    .i_wdata    (w_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_rdata_ext)
  );

  for (genvar b = 0; b < c_LANES; b++) begin : g_bank
    logic [7:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
      if (w_commit && w_be[b]) begin
        r_mem[w_idx] <= w_wdata_sh[8*b +: 8];
      end
    end

    assign w_rword[8*b +: 8] = r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (w_we | w_err) ? '0 : w_rdata_ext;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we_i;
            r_size  <= req_size_i;
            r_uns   <= req_unsigned_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            if (LATENCY == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_err_o   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// +----------------------------------------------------------------------------+
// | tb_data_mem_responder : directed bench, LATENCY=2 and LATENCY=0 instances  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  logic        a_valid = 1'b0, a_we = 1'b0, a_uns = 1'b0;
  logic [1:0]  a_size = 2'b00;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_ready, a_rvalid, a_err;
  logic [31:0] a_rdata;

  logic        b_valid = 1'b0, b_we = 1'b0, b_uns = 1'b0;
  logic [1:0]  b_size = 2'b00;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_rvalid, b_err;
  logic [31:0] b_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.D_WIDTH(32), .A_WIDTH(17), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_we_i(a_we), .req_size_i(a_size), .req_unsigned_i(a_uns),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .resp_valid_o(a_rvalid),
    .resp_rdata_o(a_rdata), .resp_err_o(a_err)
  );

  data_mem_responder #(.D_WIDTH(32), .A_WIDTH(17), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_we_i(b_we), .req_size_i(b_size), .req_unsigned_i(b_uns),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata), .resp_valid_o(b_rvalid),
    .resp_rdata_o(b_rdata), .resp_err_o(b_err)
  );

  // Drives one request on dut_a and returns the cycle (after accept) of its response.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    a_we = we; a_size = sz; a_uns = uns; a_addr = addr; a_wdata = wd; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    lat = 1;
    while (a_rvalid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = a_rdata;
    er = a_err;
    if (lat >= 20) lat = -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (a_ready !== 1'b0) $display("FAIL rst_ready_during: got %b want 0", a_ready); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (a_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", a_ready); else n_pass++;
    n_total++; if ({a_rvalid, a_err, a_rdata} !== 34'd0) $display("FAIL rst_resp_a: got v=%b e=%b d=%h want 0", a_rvalid, a_err, a_rdata); else n_pass++;
    n_total++; if ({b_ready, b_rvalid, b_err, b_rdata} !== {1'b1, 34'd0}) $display("FAIL rst_b: got r=%b v=%b e=%b d=%h want r=1 rest 0", b_ready, b_rvalid, b_err, b_rdata); else n_pass++;
  endtask

  task automatic test_store_word();
    // cycle 0: request presented, accepted at the following edge
    a_we = 1'b1; a_size = 2'b10; a_uns = 1'b0; a_addr = 32'h100; a_wdata = 32'hDEADBEEF; a_valid = 1'b1;
    n_total++; if (a_ready !== 1'b1) $display("FAIL sw_c0_ready: got %b want 1", a_ready); else n_pass++;
    @(negedge clk);
    a_valid = 1'b0; a_we = 1'b0; a_addr = 32'h200; a_wdata = 32'h01234567; a_size = 2'b00;
    n_total++; if ({a_ready, a_rvalid} !== 2'b00) $display("FAIL sw_c1: got ready=%b rv=%b want 0 0", a_ready, a_rvalid); else n_pass++;
    @(negedge clk);
    n_total++; if ({a_ready, a_rvalid} !== 2'b00) $display("FAIL sw_c2: got ready=%b rv=%b want 0 0", a_ready, a_rvalid); else n_pass++;
    @(negedge clk);
    n_total++; if ({a_ready, a_rvalid, a_err} !== 3'b010) $display("FAIL sw_c3: got ready=%b rv=%b err=%b want 0 1 0", a_ready, a_rvalid, a_err); else n_pass++;
    n_total++; if (a_rdata !== 32'h0) $display("FAIL sw_c3_rdata: got %h want 0", a_rdata); else n_pass++;
    @(negedge clk);
    n_total++; if ({a_ready, a_rvalid} !== 2'b10) $display("FAIL sw_c4: got ready=%b rv=%b want 1 0", a_ready, a_rvalid); else n_pass++;
  endtask

  task automatic test_loads();
    int lat; logic [31:0] rd; logic er;
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3) $display("FAIL ld_w100: got %h err=%b lat=%0d want deadbeef 0 3", rd, er, lat); else n_pass++;
    xact(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'hFFFFFFDE || er !== 1'b0) $display("FAIL ld_lb103: got %h err=%b want ffffffde 0", rd, er); else n_pass++;
    xact(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'h000000DE || er !== 1'b0) $display("FAIL ld_lbu103: got %h err=%b want 000000de 0", rd, er); else n_pass++;
    xact(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'hFFFFDEAD || er !== 1'b0) $display("FAIL ld_lh102: got %h err=%b want ffffdead 0", rd, er); else n_pass++;
    xact(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'h0000BEEF || er !== 1'b0) $display("FAIL ld_lhu100: got %h err=%b want 0000beef 0", rd, er); else n_pass++;
  endtask

  task automatic test_byte_store();
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 2'b00, 1'b0, 32'h101, 32'h12345655, lat, rd, er);
    n_total++; if (rd !== 32'h0 || er !== 1'b0 || lat != 3) $display("FAIL sb101: got %h err=%b lat=%0d want 0 0 3", rd, er, lat); else n_pass++;
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'hDEAD55EF || er !== 1'b0) $display("FAIL sb_readback: got %h err=%b want dead55ef 0", rd, er); else n_pass++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    xact(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'h0 || er !== 1'b1 || lat != 3) $display("FAIL err_lw102: got %h err=%b lat=%0d want 0 1 3", rd, er, lat); else n_pass++;
    xact(1'b1, 2'b01, 1'b0, 32'h101, 32'h00007777, lat, rd, er);
    n_total++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL err_sh101: got %h err=%b want 0 1", rd, er); else n_pass++;
    xact(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL err_size11: got %h err=%b want 0 1", rd, er); else n_pass++;
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'hDEAD55EF || er !== 1'b0) $display("FAIL err_unchanged: got %h err=%b want dead55ef 0", rd, er); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    int lat; logic [31:0] rd; logic er;
    @(negedge clk);
    a_we = 1'b1; a_size = 2'b10; a_addr = 32'h100; a_wdata = 32'h11111111; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;   // asserted while the counter has reached zero
    @(negedge clk);
    n_total++; if ({a_ready, a_rvalid} !== 2'b00) $display("FAIL rw_in_rst: got ready=%b rv=%b want 0 0", a_ready, a_rvalid); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if ({a_ready, a_rvalid} !== 2'b10) $display("FAIL rw_after: got ready=%b rv=%b want 1 0", a_ready, a_rvalid); else n_pass++;
    @(negedge clk);
    n_total++; if (a_rvalid !== 1'b0) $display("FAIL rw_no_pulse: got rv=%b want 0", a_rvalid); else n_pass++;
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_total++; if (rd !== 32'hDEAD55EF || er !== 1'b0) $display("FAIL rw_ram: got %h err=%b want dead55ef 0", rd, er); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    b_we = 1'b1; b_size = 2'b10; b_uns = 1'b0; b_addr = 32'h40; b_wdata = 32'hCAFEF00D; b_valid = 1'b1;
    n_total++; if (b_ready !== 1'b1) $display("FAIL bb_ready0: got %b want 1", b_ready); else n_pass++;
    @(negedge clk);
    n_total++; if ({b_ready, b_rvalid, b_err, b_rdata} !== {3'b010, 32'h0}) $display("FAIL bb_store: got r=%b v=%b e=%b d=%h want 0 1 0 0", b_ready, b_rvalid, b_err, b_rdata); else n_pass++;
    b_we = 1'b0; b_size = 2'b10; b_addr = 32'h40;
    @(negedge clk);
    n_total++; if ({b_ready, b_rvalid} !== 2'b10) $display("FAIL bb_gap1: got r=%b v=%b want 1 0", b_ready, b_rvalid); else n_pass++;
    @(negedge clk);
    n_total++; if ({b_rvalid, b_err, b_rdata} !== {2'b10, 32'hCAFEF00D}) $display("FAIL bb_lw40: got v=%b e=%b d=%h want 1 0 cafef00d", b_rvalid, b_err, b_rdata); else n_pass++;
    b_size = 2'b01; b_uns = 1'b1; b_addr = 32'h42;
    @(negedge clk);
    n_total++; if ({b_ready, b_rvalid} !== 2'b10) $display("FAIL bb_gap2: got r=%b v=%b want 1 0", b_ready, b_rvalid); else n_pass++;
    @(negedge clk);
    n_total++; if ({b_rvalid, b_err, b_rdata} !== {2'b10, 32'h0000CAFE}) $display("FAIL bb_lhu42: got v=%b e=%b d=%h want 1 0 0000cafe", b_rvalid, b_err, b_rdata); else n_pass++;
    b_size = 2'b10; b_uns = 1'b0; b_addr = 32'h20000;
    @(negedge clk);
    n_total++; if ({b_ready, b_rvalid} !== 2'b10) $display("FAIL bb_gap3: got r=%b v=%b want 1 0", b_ready, b_rvalid); else n_pass++;
    @(negedge clk);
    n_total++; if ({b_rvalid, b_err, b_rdata} !== {2'b11, 32'h0}) $display("FAIL bb_range: got v=%b e=%b d=%h want 1 1 0", b_rvalid, b_err, b_rdata); else n_pass++;
    b_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({b_ready, b_rvalid, b_rdata} !== {2'b10, 32'h0}) $display("FAIL bb_idle: got r=%b v=%b d=%h want 1 0 0", b_ready, b_rvalid, b_rdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_byte_store();
    test_errors();
    test_reset_in_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
